alu_issue: RTL and testbench

Execute-stage issue register for the RV32I core: accepts one decoded instruction per cycle from the ID stage, derives the 4-bit ALU operation code and both ALU operands, and holds them in a valid/ready pipeline register that drives the ALU's dataA, dataB and sel inputs. It is the producing end of the ALU operand/op interface. It owns stall (backpressure), flush and illegal-instruction flagging for that interface.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_decode.sv | 87 ++++++++
 rtl/alu_issue.sv | 107 ++++++++++
 tb/tb_alu_issue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry type for the RV32I ALU issue stage.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] SelAdd  = 4'b0000;
  localparam logic [3:0] SelSub  = 4'b0001;
  localparam logic [3:0] SelSll  = 4'b0010;
  localparam logic [3:0] SelSlt  = 4'b0100;
  localparam logic [3:0] SelSltu = 4'b0110;
  localparam logic [3:0] SelXor  = 4'b1000;
  localparam logic [3:0] SelSrl  = 4'b1010;
  localparam logic [3:0] SelSra  = 4'b1011;
  localparam logic [3:0] SelOr   = 4'b1100;
  localparam logic [3:0] SelAnd  = 4'b1110;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;
    logic [3:0]      sel;
    logic            illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// ID-to-issue input handshake plus the ALU operand/op output handshake.
interface alu_issue_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_dataA;
  logic [XLEN-1:0] out_dataB;
  logic [3:0]      out_sel;
  logic            out_illegal;

  modport master (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_dataA, out_dataB, out_sel, out_illegal
  );

  modport slave (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_dataA, out_dataB, out_sel, out_illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I decode of instruction/pc/register values into an ALU issue entry.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output issue_entry_t    entry_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

  always_comb begin
    entry_o = '0;
    unique case (opcode)
      OpcOp: begin
        entry_o.sel   = {funct3, funct7[5]};
        entry_o.dataA = rs1_i;
        entry_o.dataB = rs2_i;
        entry_o.illegal = !((funct7 == Funct7Zero) ||
                            ((funct7 == Funct7Alt) && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OpcOpImm: begin
        entry_o.sel   = (funct3 == 3'b101) ? {funct3, funct7[5]} : {funct3, 1'b0};
        entry_o.dataA = rs1_i;
        entry_o.dataB = imm_i;
        if (funct3 == 3'b001) begin
          entry_o.illegal = (funct7 != Funct7Zero);
        end else if (funct3 == 3'b101) begin
          entry_o.illegal = !((funct7 == Funct7Zero) || (funct7 == Funct7Alt));
        end
      end
      OpcLoad, OpcJalr: begin
        entry_o.dataA = rs1_i;
        entry_o.dataB = imm_i;
      end
      OpcStore: begin
        entry_o.dataA = rs1_i;
        entry_o.dataB = imm_s;
      end
      OpcLui: begin
        entry_o.dataB = imm_u;
      end
      OpcAuipc: begin
        entry_o.dataA = pc_i;
        entry_o.dataB = imm_u;
      end
      OpcJal: begin
        entry_o.dataA = pc_i;
        entry_o.dataB = imm_j;
      end
      OpcBranch: begin
        entry_o.dataA = rs1_i;
        entry_o.dataB = rs2_i;
        unique case (funct3[2:1])
          2'b00:   entry_o.sel = SelSub;
          2'b10:   entry_o.sel = SelSlt;
          2'b11:   entry_o.sel = SelSltu;
          default: entry_o.illegal = 1'b1;
        endcase
      end
      default: entry_o.illegal = 1'b1;
    endcase
    // Any illegal encoding issues as a zeroed ADD so the ALU sees a benign operation.
    if (entry_o.illegal) begin
      entry_o = '0;
      entry_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue register driving ALU dataA/dataB/sel with valid/ready, flush and stall.
// Optional build macro: ALU_ISSUE_SKID_EN (two-entry skid, registered in_ready).
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_issue_if.master bus
);

  issue_entry_t dec_entry;
  issue_entry_t main_q, main_d;
  logic         main_valid_q, main_valid_d;
  logic         in_fire;
  logic         out_fire;

  alu_decode u_decode (
    .instr_i (bus.in_instr),
    .pc_i    (bus.in_pc),
    .rs1_i   (bus.in_rs1_data),
    .rs2_i   (bus.in_rs2_data),
    .entry_o (dec_entry)
  );

  assign out_fire = main_valid_q && bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q;

  assign bus.in_ready = in_ready_q;
  assign in_fire      = bus.in_valid && in_ready_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // Skid holds the older entry, so it always refills main first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_d = dec_entry;
        end
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign bus.in_ready = !main_valid_q || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_d       = dec_entry;
      main_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end

  assign bus.out_valid   = main_valid_q;
  assign bus.out_dataA   = main_q.dataA;
  assign bus.out_dataB   = main_q.dataB;
  assign bus.out_sel     = main_q.sel;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed, table-driven bench for alu_issue: decode vectors plus stall, flush and reset sequences.
module tb_alu_issue;

  logic clk;
  logic rst_n;
  logic flush;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_sel;
    logic        exp_ill;
  } vec_t;

  localparam int NumVec = 18;
  localparam logic [31:0] AddInstr = 32'h002081B3;

  vec_t vecs [NumVec];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid    = v;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
  endtask

  initial begin
    int sent;
    int got;
    logic pv;
    logic pr;
    logic [31:0] pa;
    logic [3:0] ps;

    n_cmp = 0;
    n_err = 0;
    //         instr         pc            rs1           rs2           A             B             sel      ill
    vecs[0]  = '{32'h002081B3, 32'h0,        32'h5,        32'h7,        32'h5,        32'h7,        4'b0000, 1'b0};
    vecs[1]  = '{32'h402081B3, 32'h0,        32'hA,        32'h3,        32'hA,        32'h3,        4'b0001, 1'b0};
    vecs[2]  = '{32'h40315093, 32'h0,        32'hFFFF0000, 32'h0,        32'hFFFF0000, 32'h00000403, 4'b1011, 1'b0};
    vecs[3]  = '{32'h40311093, 32'h0,        32'h1234,     32'h0,        32'h0,        32'h0,        4'b0000, 1'b1};
    vecs[4]  = '{32'h12345297, 32'h100,      32'h9,        32'h0,        32'h100,      32'h12345000, 4'b0000, 1'b0};
    vecs[5]  = '{32'h0020E063, 32'h0,        32'h11,       32'h22,       32'h11,       32'h22,       4'b0110, 1'b0};
    vecs[6]  = '{32'hABCDE0B7, 32'h40,       32'h55,       32'h66,       32'h0,        32'hABCDE000, 4'b0000, 1'b0};
    vecs[7]  = '{32'hFFF10093, 32'h0,        32'h77,       32'h0,        32'h77,       32'hFFFFFFFF, 4'b0000, 1'b0};
    vecs[8]  = '{32'h0020A423, 32'h0,        32'h1000,     32'h99,       32'h1000,     32'h8,        4'b0000, 1'b0};
    vecs[9]  = '{32'h010000EF, 32'h200,      32'h3,        32'h0,        32'h200,      32'h10,       4'b0000, 1'b0};
    vecs[10] = '{32'h0020A063, 32'h0,        32'h1,        32'h2,        32'h0,        32'h0,        4'b0000, 1'b1};
    vecs[11] = '{32'h0000007F, 32'h8,        32'h1,        32'h2,        32'h0,        32'h0,        4'b0000, 1'b1};
    vecs[12] = '{32'h4020D1B3, 32'h0,        32'h80000000, 32'h4,        32'h80000000, 32'h4,        4'b1011, 1'b0};
    vecs[13] = '{32'h0FF14093, 32'h0,        32'h0F0F,     32'h0,        32'h0F0F,     32'h000000FF, 4'b1000, 1'b0};
    vecs[14] = '{32'h4020F1B3, 32'h0,        32'h3,        32'h5,        32'h0,        32'h0,        4'b0000, 1'b1};
    vecs[15] = '{32'h00315093, 32'h0,        32'hF0,       32'h0,        32'hF0,       32'h3,        4'b1010, 1'b0};
    vecs[16] = '{32'h00208063, 32'h0,        32'h4,        32'h4,        32'h4,        32'h4,        4'b0001, 1'b0};
    vecs[17] = '{32'h0020C063, 32'h0,        32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b0100, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_dataA", bus.out_dataA, 32'h0);
    check("rst_dataB", bus.out_dataB, 32'h0);
    check("rst_sel", {28'b0, bus.out_sel}, 32'h0);
    check("rst_illegal", {31'b0, bus.out_illegal}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // Decode table, streamed back to back with out_ready held high.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 32'h1);
      check($sformatf("v%0d_dataA", i), bus.out_dataA, vecs[i].exp_a);
      check($sformatf("v%0d_dataB", i), bus.out_dataB, vecs[i].exp_b);
      check($sformatf("v%0d_sel", i), {28'b0, bus.out_sel}, {28'b0, vecs[i].exp_sel});
      check($sformatf("v%0d_illegal", i), {31'b0, bus.out_illegal}, {31'b0, vecs[i].exp_ill});
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("drain_valid", {31'b0, bus.out_valid}, 32'h0);

    // Stream of four with out_ready low for three cycles mid-stream.
    sent = 0;
    got  = 0;
    pv   = 1'b0;
    pr   = 1'b1;
    pa   = 32'h0;
    ps   = 4'h0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 4) drive(1'b1, AddInstr, 32'h0, 32'h100 + sent, 32'h0);
      else drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      #4;
      if (pv && !pr) begin
        check("stall_hold_valid", {31'b0, bus.out_valid}, 32'h1);
        check("stall_hold_dataA", bus.out_dataA, pa);
        check("stall_hold_sel", {28'b0, bus.out_sel}, {28'b0, ps});
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream_order", bus.out_dataA, 32'h100 + got);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      pv = bus.out_valid;
      pr = bus.out_ready;
      pa = bus.out_dataA;
      ps = bus.out_sel;
    end
    check("stream_count", got, 32'd4);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("stream_no_dup", {31'b0, bus.out_valid}, 32'h0);

    // Flush with storage full and a handshaking input in the same cycle.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, AddInstr, 32'h0, 32'hA1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, AddInstr, 32'h0, 32'hA2, 32'h0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, AddInstr, 32'h0, 32'hA3, 32'h0);
    @(posedge clk);
    #1;
    check("flush_valid", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, AddInstr, 32'h0, 32'hA4, 32'h0);
    @(posedge clk);
    #1;
    check("post_flush_valid", {31'b0, bus.out_valid}, 32'h1);
    check("post_flush_dataA", bus.out_dataA, 32'hA4);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("post_flush_alone", {31'b0, bus.out_valid}, 32'h0);

    // Asynchronous reset while stalled.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, AddInstr, 32'h0, 32'hB1, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("async_rst_dataA", bus.out_dataA, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    bus.out_ready = 1'b1;
    drive(1'b1, AddInstr, 32'h0, 32'hB2, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    check("post_rst_dataA", bus.out_dataA, 32'hB2);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
